// File: rtl/packet_receiver.sv
`default_nettype none
// ============================================================================
// Module   : packet_receiver
// Purpose  : Frames header/length/payload/XOR-checksum packets into a byte RAM.
// Revision : 1.0
// ============================================================================
module packet_receiver #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        word,
  input  logic              word_valid,
  input  logic              header_found,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              pkt_type,
  output logic [ADDR_W-1:0] pkt_len,
  output logic              pkt_done,
  output logic              pkt_err,
  output logic              busy
);

  localparam int                c_max_len = (1 << ADDR_W) - 1;
  localparam int                c_tw      = $clog2(TIMEOUT + 1);
  localparam logic [c_tw-1:0]   c_tlast   = c_tw'(TIMEOUT - 1);
  localparam logic [c_tw-1:0]   c_tone    = c_tw'(1);
  localparam logic [ADDR_W-1:0] c_aone    = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LEN     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CHK     = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_cnt;
  logic [7:0]        r_csum;
  logic [c_tw-1:0]   r_tcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_cnt     <= '0;
      r_csum    <= '0;
      r_tcnt    <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      pkt_type  <= 1'b0;
      pkt_len   <= '0;
      pkt_done  <= 1'b0;
      pkt_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ram_we   <= 1'b0;
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
      if (r_state == S_IDLE) begin
        r_tcnt <= '0;
        if (word_valid && header_found) begin
          pkt_type <= word[6];
          r_state  <= S_LEN;
          busy     <= 1'b1;
        end
      end else if (word_valid) begin
        // An arriving byte always beats a timeout expiring on the same cycle.
        r_tcnt <= '0;
        case (r_state)
          S_LEN: begin
            r_cnt  <= '0;
            r_csum <= '0;
            if (int'(word) > c_max_len) begin
              pkt_err <= 1'b1;
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end else begin
              r_len   <= ADDR_W'(word);
              r_state <= (word == 8'h00) ? S_CHK : S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            ram_we    <= 1'b1;
            ram_addr  <= r_cnt;
            ram_wdata <= word;
            r_csum    <= r_csum ^ word;
            r_cnt     <= r_cnt + c_aone;
            if (r_cnt == r_len - c_aone) begin
              r_state <= S_CHK;
            end
          end
          S_CHK: begin
            if (word == r_csum) begin
              pkt_done <= 1'b1;
              pkt_len  <= r_len;
            end else begin
              pkt_err <= 1'b1;
            end
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end else if (r_tcnt == c_tlast) begin
        pkt_err <= 1'b1;
        r_tcnt  <= '0;
        r_state <= S_IDLE;
        busy    <= 1'b0;
      end else begin
        r_tcnt <= r_tcnt + c_tone;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_packet_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_packet_receiver
// Purpose  : Scoreboard bench for packet_receiver (RAM writes and end pulses).
// Revision : 1.0
// ============================================================================
module tb_packet_receiver;

  localparam int ADDR_W  = 6;
  localparam int TIMEOUT = 1000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        word = 8'h00;
  logic              word_valid = 1'b0;
  logic              header_found = 1'b0;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              pkt_type;
  logic [ADDR_W-1:0] pkt_len;
  logic              pkt_done;
  logic              pkt_err;
  logic              busy;

  packet_receiver #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .word         (word),
    .word_valid   (word_valid),
    .header_found (header_found),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .pkt_type     (pkt_type),
    .pkt_len      (pkt_len),
    .pkt_done     (pkt_done),
    .pkt_err      (pkt_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // kind: 0 = RAM write, 1 = pkt_done, 2 = pkt_err
  typedef struct packed {
    logic [1:0]        kind;
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
    logic [ADDR_W-1:0] len;
    logic              typ;
  } ev_t;

  ev_t        sb[$];
  logic [7:0] pl[$];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pkt_done || pkt_err)
        check("done_err_excl", {31'd0, pkt_done & pkt_err}, 32'd0);
      if (ram_we || pkt_done || pkt_err) begin
        if (sb.size() == 0) begin
          check("unexpected_event", 32'd1, 32'd0);
        end else begin
          ev_t e;
          e = sb.pop_front();
          if (ram_we) begin
            check("wr_kind", 32'd0, {30'd0, e.kind});
            check("wr_addr", {26'd0, ram_addr}, {26'd0, e.a});
            check("wr_data", {24'd0, ram_wdata}, {24'd0, e.d});
          end else begin
            check("end_kind", pkt_done ? 32'd1 : 32'd2, {30'd0, e.kind});
            check("pkt_type", {31'd0, pkt_type}, {31'd0, e.typ});
            if (pkt_done) check("pkt_len", {26'd0, pkt_len}, {26'd0, e.len});
          end
        end
      end
    end
  end

  task automatic push_ev(input logic [1:0] k, input int a, input logic [7:0] d,
                         input int len, input logic typ);
    ev_t e;
    e.kind = k;
    e.a    = ADDR_W'(a);
    e.d    = d;
    e.len  = ADDR_W'(len);
    e.typ  = typ;
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    word         = b;
    word_valid   = 1'b1;
    header_found = (b == 8'hA5) || (b == 8'hC3);
    @(posedge clk);
    #1;
    word_valid   = 1'b0;
    header_found = 1'b0;
    word         = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends hdr, len, pl[] and chk, after queueing the outcome a correct receiver produces.
  task automatic run_pkt(input logic [7:0] hdr, input logic [7:0] len,
                         input logic [7:0] chk, input bit settle);
    logic [7:0] csum;
    csum = 8'h00;
    if (int'(len) > (1 << ADDR_W) - 1) begin
      push_ev(2'd2, 0, 8'h00, 0, hdr[6]);
      send(hdr);
      send(len);
    end else begin
      for (int i = 0; i < int'(len); i++) begin
        push_ev(2'd0, i, pl[i], 0, hdr[6]);
        csum = csum ^ pl[i];
      end
      if (chk == csum) push_ev(2'd1, 0, 8'h00, int'(len), hdr[6]);
      else             push_ev(2'd2, 0, 8'h00, 0, hdr[6]);
      send(hdr);
      send(len);
      for (int i = 0; i < int'(len); i++) send(pl[i]);
      send(chk);
    end
    if (settle) idle(2);
  endtask

  initial begin
    #2;
    check("reset_outputs", {15'd0, ram_we, ram_addr, ram_wdata, pkt_type, pkt_len,
                            pkt_done, pkt_err, busy}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    check("busy_after_reset", {31'd0, busy}, 32'd0);

    // Non-header bytes in IDLE are ignored.
    send(8'h00);
    send(8'h7F);
    idle(1);
    check("busy_idle_bytes", {31'd0, busy}, 32'd0);

    // Basic A5 packet.
    pl = '{8'h11, 8'h22, 8'h33};
    run_pkt(8'hA5, 8'h03, 8'h00, 1'b1);

    // C3 packet with header-valued payload bytes.
    pl = '{8'hA5, 8'hC3};
    run_pkt(8'hC3, 8'h02, 8'h66, 1'b1);

    // Bad checksum, then a header on the very next cycle.
    pl = '{8'h10, 8'h20};
    run_pkt(8'hA5, 8'h02, 8'h31, 1'b0);
    check("busy_after_err", {31'd0, busy}, 32'd0);
    pl = '{};
    run_pkt(8'hA5, 8'h00, 8'h00, 1'b1);

    // Length at and above the maximum.
    pl = '{};
    run_pkt(8'hC3, 8'h40, 8'h00, 1'b1);
    check("busy_after_badlen", {31'd0, busy}, 32'd0);
    pl = '{};
    for (int i = 0; i < 63; i++) pl.push_back(8'($urandom_range(0, 255)));
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < 63; i++) x = x ^ pl[i];
      run_pkt(8'hC3, 8'd63, x, 1'b1);
    end

    // Timeout mid-payload.
    push_ev(2'd0, 0, 8'h01, 0, 1'b0);
    push_ev(2'd2, 0, 8'h00, 0, 1'b0);
    send(8'hA5);
    send(8'h04);
    send(8'h01);
    idle(TIMEOUT - 1);
    check("tmo_not_early", {31'd0, pkt_err}, 32'd0);
    check("tmo_busy_held", {31'd0, busy}, 32'd1);
    idle(1);
    check("tmo_err_pulse", {31'd0, pkt_err}, 32'd1);
    check("tmo_busy_drop", {31'd0, busy}, 32'd0);
    idle(2);

    // A byte landing on the expiry cycle wins.
    push_ev(2'd0, 0, 8'h5A, 0, 1'b1);
    push_ev(2'd1, 0, 8'h00, 1, 1'b1);
    send(8'hC3);
    send(8'h01);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    send(8'h5A);
    send(8'h5A);
    idle(2);

    // Reset mid-payload clears everything with no pulse.
    push_ev(2'd0, 0, 8'h11, 0, 1'b1);
    push_ev(2'd0, 1, 8'h22, 0, 1'b1);
    send(8'hC3);
    send(8'h05);
    send(8'h11);
    send(8'h22);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {15'd0, ram_we, ram_addr, ram_wdata, pkt_type, pkt_len,
                          pkt_done, pkt_err, busy}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    pl = '{8'h0F, 8'hF0};
    run_pkt(8'hA5, 8'h02, 8'hFF, 1'b1);
    check("len_after_fresh", {26'd0, pkt_len}, 32'd2);

    idle(4);
    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
